// File: rtl/ebpf_lsu.sv
// ebpf_lsu: load/store unit for the eBPF core's 64-bit data memory.
//
// Accepts one LDX/STX request at a time and checks it for alignment and
// range. It then runs a read, a write, or a read-modify-write on the word
// bus and returns zero-extended load data or an error. Every output is
// registered. Each output register is loaded from the value that belongs
// to the state being entered.
//
// Ports
//   clk, rst_n        : clock; synchronous active-low reset
//   req_valid/ready   : request handshake (ready only while idle)
//   req_we/size/addr/wdata : store flag, size code (B/H/W/DW), byte address,
//                       and right-aligned store data
//   resp_valid/rdata/err : one-cycle completion pulse with load data or error
//   stb/adr/we/ww/dat_w : bus request (word address, one-hot size code)
//   dat_r, data_ack   : bus read data and phase acknowledge
module ebpf_lsu #(
   parameter int DATA_SIZE = 64,
   parameter int ADDR_SIZE = 11,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [1:0]           req_size,
   input  logic [63:0]          req_addr,
   input  logic [63:0]          req_wdata,
   output logic                 resp_valid,
   output logic [63:0]          resp_rdata,
   output logic                 resp_err,
   output logic                 stb,
   output logic [ADDR_SIZE-1:0] adr,
   output logic                 we,
   output logic [3:0]           ww,
   output logic [DATA_SIZE-1:0] dat_w,
   input  logic [63:0]          dat_r,
   input  logic                 data_ack
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CHK, RD, WR, RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [63:0] addr;
      logic [63:0] wdata;
   } req_t;

   state_t               state_q, state_d;
   req_t                 req_q, req_d;
   logic [DATA_SIZE-1:0] merge_q, merge_d;   // DW store data, or the RMW merged word
   logic [CW-1:0]        cnt_q, cnt_d;

   logic                 req_ready_d, resp_valid_d, resp_err_d, stb_d, we_d;
   logic [63:0]          resp_rdata_d;
   logic [ADDR_SIZE-1:0] adr_d;
   logic [3:0]           ww_d;
   logic [DATA_SIZE-1:0] dat_w_d;

   logic [5:0]           shamt;
   logic [63:0]          size_mask;
   logic [2:0]           align_mask;
   logic [63:0]          lane;
   logic [63:0]          merged;
   logic                 misalign, out_of_range, timed_out;

   // Size-derived masks and byte-lane datapath
   always_comb begin
      size_mask  = '1;
      align_mask = 3'd7;
      case (req_q.size)
         2'd0: begin size_mask = 64'h0000_0000_0000_00ff; align_mask = 3'd0; end
         2'd1: begin size_mask = 64'h0000_0000_0000_ffff; align_mask = 3'd1; end
         2'd2: begin size_mask = 64'h0000_0000_ffff_ffff; align_mask = 3'd3; end
         default: ;
      endcase
      shamt        = {req_q.addr[2:0], 3'b000};
      lane         = (dat_r >> shamt) & size_mask;
      // Only the addressed bytes are replaced; the rest of the word is preserved.
      merged       = (dat_r & ~(size_mask << shamt)) | ((req_q.wdata & size_mask) << shamt);
      misalign     = (req_q.addr[2:0] & align_mask) != 3'd0;
      out_of_range = |req_q.addr[63:ADDR_SIZE+3];
      timed_out    = (cnt_q == CW'(TIMEOUT - 1));
   end

   // Next state and next registered outputs
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      merge_d      = merge_q;
      cnt_d        = cnt_q;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               req_d   = '{we: req_we, size: req_size, addr: req_addr, wdata: req_wdata};
               merge_d = req_wdata;
               state_d = CHK;
            end
         end
         CHK: begin
            cnt_d = '0;
            if (misalign || out_of_range) begin
               resp_err_d = 1'b1;
               state_d    = RESP;
            end else if (req_q.we && req_q.size == 2'd3) begin
               state_d = WR;
            end else begin
               state_d = RD;            // load, or the read half of a sub-word store
            end
         end
         RD: begin
            if (data_ack) begin
               if (!req_q.we) begin
                  resp_rdata_d = lane;
                  state_d      = RESP;
               end else begin
                  merge_d = merged;
                  cnt_d   = '0;
                  state_d = WR;
               end
            end else if (timed_out) begin
               resp_err_d = 1'b1;       // a pending RMW write is abandoned
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR: begin
            if (data_ack) begin
               state_d = RESP;
            end else if (timed_out) begin
               resp_err_d = 1'b1;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Bus outputs are held constant for the whole phase.
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
      stb_d        = (state_d == RD) || (state_d == WR);
      we_d         = (state_d == WR);
      adr_d        = stb_d ? req_d.addr[ADDR_SIZE+2:3] : '0;
      ww_d         = (state_d == WR) ? 4'b1000 :
                     (state_d == RD) ? (4'b0001 << req_d.size) : 4'b0000;
      dat_w_d      = (state_d == WR) ? merge_d : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_q      <= '0;
         merge_q    <= '0;
         cnt_q      <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         stb        <= 1'b0;
         adr        <= '0;
         we         <= 1'b0;
         ww         <= '0;
         dat_w      <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         merge_q    <= merge_d;
         cnt_q      <= cnt_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_err   <= resp_err_d;
         stb        <= stb_d;
         adr        <= adr_d;
         we         <= we_d;
         ww         <= ww_d;
         dat_w      <= dat_w_d;
      end
   end

endmodule

// File: tb/tb_ebpf_lsu.sv
// tb_ebpf_lsu: randomized self-checking bench for ebpf_lsu.
// The bus memory is held as 64-bit words and serves the DUT. An
// independent byte-array model predicts load results and store effects.
module tb_ebpf_lsu;
   localparam int AS = 11;
   localparam int NW = 1 << AS;
   localparam int NB = NW * 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [1:0]    req_size = '0;
   logic [63:0]   req_addr = '0, req_wdata = '0;
   logic          resp_valid, resp_err;
   logic [63:0]   resp_rdata;
   logic          stb, we;
   logic [AS-1:0] adr;
   logic [3:0]    ww;
   logic [63:0]   dat_w;
   logic [63:0]   dat_r = '0;
   logic          data_ack = 1'b0;

   always #5 clk = ~clk;

   ebpf_lsu #(.DATA_SIZE(64), .ADDR_SIZE(AS), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .stb(stb), .adr(adr), .we(we), .ww(ww), .dat_w(dat_w),
      .dat_r(dat_r), .data_ack(data_ack)
   );

   logic [63:0] mem  [NW];
   logic [7:0]  refm [NB];
   int checks = 0, errors = 0;

   bit bus_en = 1'b1, noise = 1'b0;
   int min_wait = 0, max_wait = 0, wcnt = 0, wtarget = 0;
   logic [63:0]   last_wr_data = '0;
   logic [3:0]    last_wr_ww = '0, last_rd_ww = '0;
   logic [AS-1:0] last_rd_adr = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bus slave: acks after a drawn number of wait cycles.
   // Random ack noise is applied only while stb is low.
   always @(negedge clk) begin
      data_ack = 1'b0;
      if (!rst_n) wcnt = 0;
      else if (stb) begin
         if (wcnt == 0) wtarget = min_wait + int'($urandom_range(0, max_wait - min_wait));
         if (bus_en && wcnt >= wtarget) begin
            data_ack = 1'b1;
            dat_r    = mem[adr];
            if (we) begin mem[adr] = dat_w; last_wr_data = dat_w; last_wr_ww = ww; end
            else    begin last_rd_adr = adr; last_rd_ww = ww; end
            wcnt = 0;
         end else wcnt++;
      end else begin
         wcnt = 0;
         if (noise) begin
            data_ack = 1'($urandom_range(0, 1));
            dat_r    = {$urandom, $urandom};
         end
      end
   end

   task automatic set_word(input int i, input logic [63:0] v);
      mem[i] = v;
      for (int k = 0; k < 8; k++) refm[i*8+k] = v[8*k +: 8];
   endtask

   function automatic logic [63:0] ref_load(input logic [63:0] a, input int nb);
      logic [63:0] v = '0;
      for (int k = 0; k < nb; k++) v |= 64'(refm[int'(a) + k]) << (8 * k);
      return v;
   endfunction

   task automatic run_txn(input bit w, input logic [1:0] sz, input logic [63:0] a,
                          input logic [63:0] d, input bit to_exp, input int exp_lat,
                          input int exp_stb, input string tag);
      int nb = 1 << sz;
      bit e;
      logic [63:0] er = '0;
      int cyc = 0, sc = 0, n = 0;
      bit got = 1'b0;
      logic gerr = 1'b0;
      logic [63:0] grd = '0;
      e = (a % 64'(nb) != 0) || (a >= 64'(NB));
      if (!e && to_exp) e = 1'b1;
      else if (!e && !w) er = ref_load(a, nb);
      else if (!e && w) for (int k = 0; k < nb; k++) refm[int'(a) + k] = d[8*k +: 8];

      @(negedge clk);
      req_valid = 1'b1; req_we = w; req_size = sz; req_addr = a; req_wdata = d;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk({tag, ".ready"}, 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      while (!got && cyc < 60) begin
         @(negedge clk); cyc++;
         if (stb) sc++;
         if (resp_valid) begin got = 1'b1; gerr = resp_err; grd = resp_rdata; end
      end
      chk({tag, ".valid"}, 64'(got), 64'd1);
      chk({tag, ".err"},   64'(gerr), 64'(e));
      chk({tag, ".rdata"}, grd, er);
      if (exp_lat >= 0) chk({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
      if (exp_stb >= 0) chk({tag, ".stbcyc"}, 64'(sc), 64'(exp_stb));
      @(negedge clk);
      chk({tag, ".pulse"}, 64'(resp_valid), 64'd0);
   endtask

   initial begin
      int bad;
      for (int i = 0; i < NW; i++) set_word(i, {$urandom, $urandom});

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.ready", 64'(req_ready), 64'd0);
      chk("rst.stb",   64'(stb), 64'd0);
      chk("rst.resp",  64'(resp_valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.ready_after", 64'(req_ready), 64'd1);

      // Directed cases, zero-wait bus
      set_word(2, 64'h8877665544332211);
      run_txn(1'b0, 2'd0, 64'h13, 64'h0, 1'b0, 3, 1, "ldb");
      chk("ldb.adr", 64'(last_rd_adr), 64'd2);
      chk("ldb.ww",  64'(last_rd_ww), 64'b0001);

      set_word(1, 64'h1111111111111111);
      run_txn(1'b1, 2'd1, 64'h0A, 64'hFFFFBEEF, 1'b0, 4, 2, "sth");
      chk("sth.datw", last_wr_data, 64'h11111111BEEF1111);
      chk("sth.ww",   64'(last_wr_ww), 64'b1000);
      chk("sth.rdww", 64'(last_rd_ww), 64'b0010);

      run_txn(1'b0, 2'd2, 64'h06, 64'h0, 1'b0, 2, 0, "misal");
      run_txn(1'b0, 2'd3, 64'h4000, 64'h0, 1'b0, 2, 0, "oor");
      run_txn(1'b1, 2'd3, 64'h40, 64'hCAFEF00D12345678, 1'b0, 3, 1, "stdw");
      chk("stdw.datw", last_wr_data, 64'hCAFEF00D12345678);

      // Timeout, then ack landing on the last allowed cycle
      bus_en = 1'b0;
      run_txn(1'b1, 2'd3, 64'h80, 64'hDEADBEEF00000001, 1'b1, 18, 16, "tmo");
      bus_en = 1'b1; min_wait = 15; max_wait = 15;
      run_txn(1'b1, 2'd3, 64'h88, 64'hDEADBEEF00000002, 1'b0, 18, 16, "ack16");
      run_txn(1'b1, 2'd0, 64'h91, 64'h5A, 1'b0, 34, 32, "rmw16");
      min_wait = 0; max_wait = 0;

      // Reset while a read phase is waiting on the bus
      bus_en = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h100;
      @(posedge clk);
      #1 req_valid = 1'b0;
      bad = 0;
      while (!stb && bad < 10) begin @(negedge clk); bad++; end
      chk("mid.stb_seen", 64'(stb), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid.stb",   64'(stb), 64'd0);
      chk("mid.ready", 64'(req_ready), 64'd0);
      chk("mid.resp",  64'(resp_valid), 64'd0);
      rst_n = 1'b1; bus_en = 1'b1;
      @(negedge clk);
      chk("mid.ready_after", 64'(req_ready), 64'd1);
      bad = 0;
      repeat (4) begin @(negedge clk); if (resp_valid) bad++; end
      chk("mid.no_resp", 64'(bad), 64'd0);
      run_txn(1'b0, 2'd3, 64'h10, 64'h0, 1'b0, 3, 1, "post_rst");

      // Randomized traffic with bus waits and stray acks
      noise = 1'b1; max_wait = 3;
      for (int t = 0; t < 250; t++) begin
         logic [1:0] sz = 2'($urandom);
         int nb = 1 << sz;
         int r = int'($urandom_range(0, 15));
         logic [63:0] a;
         if (r == 0)      a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
         else if (r == 1) a = 64'($urandom % NB);
         else             a = 64'(($urandom % NB) & ~(nb - 1));
         run_txn(1'($urandom), sz, a, {$urandom, $urandom}, 1'b0, -1, -1, "rnd");
      end
      noise = 1'b0;

      // Whole memory image against the byte model
      bad = 0;
      for (int i = 0; i < NW; i++)
         for (int k = 0; k < 8; k++)
            if (mem[i][8*k +: 8] !== refm[i*8+k]) bad++;
      chk("mem_image", 64'(bad), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
